glyph_sprite: RTL and testbench

Parametrised multi-glyph sprite renderer for the VGA music-notation display. It holds a bank of accidental glyphs (blank, sharp, flat, natural) in an on-chip ROM. It places one selected glyph at a programmable screen origin with power-of-two pixel scaling, and returns a per-pixel on/off for the current raster position through a fixed 2-cycle pipeline. Position and glyph updates use a valid/ready handshake and are double-buffered, so they only take effect at a frame boundary and never tear mid-frame.

---
 rtl/glyph_sprite.sv | 204 ++++++++++++++++++++
 tb/tb_glyph_sprite.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_sprite.sv
// Accidental-glyph sprite renderer: ROM bank, scaled placement, 2-cycle pixel pipe.
// Optional blinking is enabled by defining GLYPH_BLINK_EN.
module glyph_sprite #(
  parameter int GLYPH_W      = 10,
  parameter int GLYPH_H      = 16,
  parameter int NUM_GLYPHS   = 4,
  parameter int SCALE_LOG2   = 1,
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [$clog2(NUM_GLYPHS)-1:0] upd_glyph,
  input  logic [COORD_W-1:0]            upd_x,
  input  logic [COORD_W-1:0]            upd_y,
`ifdef GLYPH_BLINK_EN
  input  logic                          upd_blink,
`endif
  input  logic                          pix_req,
  input  logic [COORD_W-1:0]            hcount,
  input  logic [COORD_W-1:0]            vcount,
  output logic                          pix_valid,
  output logic                          pix_on
);

  localparam int GSEL_W = $clog2(NUM_GLYPHS);
  localparam int ROM_N  = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int AW     = $clog2(ROM_N);
  localparam logic [COORD_W:0] BOX_W =
    (COORD_W+1)'(GLYPH_W << SCALE_LOG2);
  localparam logic [COORD_W:0] BOX_H =
    (COORD_W+1)'(GLYPH_H << SCALE_LOG2);

  function automatic logic glyph_px(int g, int r, int c);
    case (g)
      1: return (c == 3) || (c == 6)
             || (r == 4  && c >= 1 && c <= 8)
             || (r == 5  && c >= 2 && c <= 9)
             || (r == 10 && c <= 7)
             || (r == 11 && c >= 1 && c <= 8);
      2: return (c == 2)
             || (r >= 9 && r <= 15 && c >= 3 && c <= 7
                 && (r == 9 || r == 15 || c == 3 || c == 7));
      3: return (c == 2 && r <= 11)
             || (c == 7 && r >= 4)
             || ((r == 4 || r == 5 || r == 10 || r == 11)
                 && c >= 2 && c <= 7);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ROM_N-1:0] build_rom();
    logic [ROM_N-1:0] v;
    v = '0;
    for (int g = 0; g < NUM_GLYPHS; g++)
      for (int r = 0; r < GLYPH_H; r++)
        for (int c = 0; c < GLYPH_W; c++)
          v[AW'(g*GLYPH_W*GLYPH_H + r*GLYPH_W + c)] =
            glyph_px(g, r, c);
    return v;
  endfunction

  localparam logic [ROM_N-1:0] ROM = build_rom();

  logic [GSEL_W-1:0]  act_g_q, act_g_d, pnd_g_q, pnd_g_d;
  logic [COORD_W-1:0] act_x_q, act_x_d, pnd_x_q, pnd_x_d;
  logic [COORD_W-1:0] act_y_q, act_y_d, pnd_y_q, pnd_y_d;
  logic               pend_q, pend_d;
  logic               accept, commit, visible;

  assign upd_ready = !pend_q;
  assign accept    = upd_valid && !pend_q;
  assign commit    = frame_start && pend_q;

  always_comb begin
    act_g_d = act_g_q;
    act_x_d = act_x_q;
    act_y_d = act_y_q;
    pnd_g_d = pnd_g_q;
    pnd_x_d = pnd_x_q;
    pnd_y_d = pnd_y_q;
    pend_d  = pend_q;
    if (commit) begin
      act_g_d = pnd_g_q;
      act_x_d = pnd_x_q;
      act_y_d = pnd_y_q;
      pend_d  = 1'b0;
    end else if (accept) begin
      pnd_g_d = upd_glyph;
      pnd_x_d = upd_x;
      pnd_y_d = upd_y;
      pend_d  = 1'b1;
    end
  end

`ifdef GLYPH_BLINK_EN
  localparam int CW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic          act_b_q, act_b_d, pnd_b_q, pnd_b_d;
  logic          vis_q, vis_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    act_b_d = act_b_q;
    pnd_b_d = pnd_b_q;
    vis_d   = vis_q;
    cnt_d   = cnt_q;
    if (commit) act_b_d = pnd_b_q;
    else if (accept) pnd_b_d = upd_blink;
    // A fresh blink start always begins in the visible phase.
    if (commit && pnd_b_q && !act_b_q) begin
      cnt_d = '0;
      vis_d = 1'b1;
    end else if (!act_b_q) begin
      vis_d = 1'b1;
    end else if (frame_start) begin
      if (cnt_q == CW'(BLINK_FRAMES-1)) begin
        cnt_d = '0;
        vis_d = !vis_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_b_q <= 1'b0;
      pnd_b_q <= 1'b0;
      vis_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      act_b_q <= act_b_d;
      pnd_b_q <= pnd_b_d;
      vis_q   <= vis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign visible = !act_b_q || vis_q;
`else
  assign visible = 1'b1;
`endif

  logic [COORD_W:0] dx, dy, col, row;
  logic             glyph_ok;
  logic             in_box_d, in_box_q;
  logic             req1_q;
  logic [AW-1:0]    addr_d, addr_q;
  int unsigned      addr_lin;
  logic             on_d, on_q, valid_q;

  always_comb begin
    dx       = {1'b0, hcount} - {1'b0, act_x_q};
    dy       = {1'b0, vcount} - {1'b0, act_y_q};
    col      = dx >> SCALE_LOG2;
    row      = dy >> SCALE_LOG2;
    glyph_ok = (int'(act_g_q) < NUM_GLYPHS);
    in_box_d = pix_req && glyph_ok
            && !dx[COORD_W] && (dx < BOX_W)
            && !dy[COORD_W] && (dy < BOX_H);
    addr_lin = int'(act_g_q) * GLYPH_W * GLYPH_H
             + int'(row) * GLYPH_W + int'(col);
    addr_d   = in_box_d ? AW'(addr_lin) : '0;
    on_d     = req1_q && in_box_q && ROM[addr_q] && visible;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_g_q  <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      pnd_g_q  <= '0;
      pnd_x_q  <= '0;
      pnd_y_q  <= '0;
      pend_q   <= 1'b0;
      req1_q   <= 1'b0;
      in_box_q <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      on_q     <= 1'b0;
    end else begin
      act_g_q  <= act_g_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      pnd_g_q  <= pnd_g_d;
      pnd_x_q  <= pnd_x_d;
      pnd_y_q  <= pnd_y_d;
      pend_q   <= pend_d;
      req1_q   <= pix_req;
      in_box_q <= in_box_d;
      addr_q   <= addr_d;
      valid_q  <= req1_q;
      on_q     <= on_d;
    end
  end

  assign pix_valid = valid_q;
  assign pix_on    = on_q;

endmodule

// File: tb/tb_glyph_sprite.sv
// Directed bench for glyph_sprite with a pixel scoreboard and handshake model.
module tb_glyph_sprite;

  localparam int GW = 10;
  localparam int GH = 16;
  localparam int S  = 1;
  localparam int CW = 10;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [1:0]    upd_glyph = '0;
  logic [CW-1:0] upd_x = '0;
  logic [CW-1:0] upd_y = '0;
  logic          upd_blink = 1'b0;
  logic          pix_req = 1'b0;
  logic [CW-1:0] hcount = '0;
  logic [CW-1:0] vcount = '0;
  logic          pix_valid;
  logic          pix_on;

  always #5 clk = ~clk;

  glyph_sprite #(
    .GLYPH_W(GW), .GLYPH_H(GH), .NUM_GLYPHS(4),
    .SCALE_LOG2(S), .COORD_W(CW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_glyph(upd_glyph),
    .upd_x(upd_x),
    .upd_y(upd_y),
`ifdef GLYPH_BLINK_EN
    .upd_blink(upd_blink),
`endif
    .pix_req(pix_req),
    .hcount(hcount),
    .vcount(vcount),
    .pix_valid(pix_valid),
    .pix_on(pix_on)
  );

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  int force_exp = -1;

  int m_g, m_x, m_y, p_g, p_x, p_y, m_cnt;
  bit m_b, p_b, m_pend, m_vis;
  bit h1, h2;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit rom_px(int g, int r, int c);
    if (g == 1) begin
      if (c == 3 || c == 6) return 1;
      if (r == 4)  return c inside {[1:8]};
      if (r == 5)  return c inside {[2:9]};
      if (r == 10) return c inside {[0:7]};
      if (r == 11) return c inside {[1:8]};
      return 0;
    end
    if (g == 2) begin
      if (c == 2) return 1;
      if (!(r inside {[9:15]}) || !(c inside {[3:7]})) return 0;
      return r == 9 || r == 15 || c == 3 || c == 7;
    end
    if (g == 3) begin
      if (c == 2 && r <= 11) return 1;
      if (c == 7 && r >= 4) return 1;
      return (r inside {4, 5, 10, 11}) && (c inside {[2:7]});
    end
    return 0;
  endfunction

  function automatic bit model_pix(int h, int v);
    int dx, dy;
    bit vis;
    dx  = h - m_x;
    dy  = v - m_y;
    vis = m_b ? m_vis : 1'b1;
    if (dx < 0 || dx >= (GW << S)) return 0;
    if (dy < 0 || dy >= (GH << S)) return 0;
    return rom_px(m_g, dy >> S, dx >> S) && vis;
  endfunction

  task automatic cyc();
    bit commit, accept;
    if (reset) begin
      m_g = 0; m_x = 0; m_y = 0; m_b = 0;
      m_pend = 0; m_vis = 1; m_cnt = 0;
      h1 = 0; h2 = 0;
      exp_q.delete();
    end else begin
      if (pix_req) begin
        if (force_exp < 0) exp_q.push_back(model_pix(hcount, vcount));
        else exp_q.push_back(force_exp[0]);
      end
      h2 = h1;
      h1 = pix_req;
      commit = frame_start && m_pend;
      accept = upd_valid && !m_pend;
      if (commit && p_b && !m_b) begin
        m_cnt = 0; m_vis = 1;
      end else if (!m_b) begin
        m_vis = 1;
      end else if (frame_start) begin
        if (m_cnt == BF - 1) begin
          m_cnt = 0; m_vis = !m_vis;
        end else m_cnt++;
      end
      if (commit) begin
        m_g = p_g; m_x = p_x; m_y = p_y; m_b = p_b; m_pend = 0;
      end else if (accept) begin
        p_g = upd_glyph; p_x = upd_x; p_y = upd_y;
`ifdef GLYPH_BLINK_EN
        p_b = upd_blink;
`else
        p_b = 0;
`endif
        m_pend = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("upd_ready", upd_ready, !m_pend);
    chk("pix_valid_shift", pix_valid, h2);
    if (pix_valid) begin
      if (exp_q.size() == 0) chk("sb_underflow", pix_valid, 1'b0);
      else chk("pix_on", pix_on, exp_q.pop_front());
    end else begin
      chk("pix_on_idle", pix_on, 1'b0);
    end
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic px(int h, int v, int k = -1);
    pix_req = 1; hcount = CW'(h); vcount = CW'(v); force_exp = k;
    cyc();
    pix_req = 0; force_exp = -1;
  endtask

  task automatic fs();
    frame_start = 1;
    cyc();
    frame_start = 0;
  endtask

  task automatic upd(int g, int x, int y, bit b = 0);
    upd_valid = 1; upd_glyph = 2'(g);
    upd_x = CW'(x); upd_y = CW'(y); upd_blink = b;
    cyc();
    upd_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk("rst_ready", upd_ready, 1'b1);
    chk("rst_valid", pix_valid, 1'b0);
    chk("rst_pix_on", pix_on, 1'b0);
    reset = 0;
    px(0, 0, 0); px(5, 7, 0); px(300, 400, 0);
    idle(2);

    upd(1, 100, 50);
    chk("pending_not_ready", upd_ready, 1'b0);
    px(106, 50, 0); px(100, 70, 0);
    idle(3);
    fs();
    chk("ready_after_commit", upd_ready, 1'b1);
    px(106, 50, 1); px(100, 50, 0); px(100, 70, 1);
    px(99, 50, 0); px(120, 50, 0); px(113, 50, 1);
    px(119, 81, 0); px(100, 82, 0);
    idle(2);

    upd(2, 200, 100);
    upd_valid = 1; upd_glyph = 2'd3;
    upd_x = CW'(300); upd_y = CW'(200);
    idle(3);
    chk("backpressure_hold", upd_ready, 1'b0);
    frame_start = 1; pix_req = 1;
    hcount = CW'(106); vcount = CW'(50); force_exp = 1;
    cyc();
    frame_start = 0; pix_req = 0; force_exp = -1;
    chk("ready_reopens", upd_ready, 1'b1);
    cyc();
    upd_valid = 0;
    chk("second_accepted", upd_ready, 1'b0);
    px(204, 100, 1); px(206, 118, 1); px(210, 124); px(199, 100, 0);
    idle(2);
    fs();
    px(304, 200, 1); px(314, 200, 0); px(314, 208, 1); px(310, 220);
    idle(2);

    upd_valid = 1; upd_glyph = 2'd1; upd_x = '0; upd_y = '0;
    fs();
    upd_valid = 0;
    chk("same_cycle_pending", upd_ready, 1'b0);
    px(304, 200, 1); px(6, 0, 0);
    idle(2);
    fs();
    px(6, 0, 1); px(0, 20, 1);

    for (int i = 0; i < 20; i++) begin
      pix_req = (i % 5 != 4);
      hcount = CW'($urandom_range(0, 25));
      vcount = CW'($urandom_range(0, 35));
      cyc();
    end
    pix_req = 0;
    idle(3);

    upd(2, 50, 50);
    reset = 1;
    cyc();
    reset = 0;
    chk("reset_drops_pending", upd_ready, 1'b1);
    fs();
    px(54, 50, 0); px(6, 0, 0);
    idle(2);

`ifdef GLYPH_BLINK_EN
    upd(1, 100, 50, 1);
    fs();
    for (int f = 0; f < 8; f++) begin
      if (f > 0) fs();
      idle(3);
      px(106, 50, ((f % 4) < 2) ? 1 : 0);
      px(113, 70);
      idle(2);
    end
    reset = 1;
    cyc();
    reset = 0;
    px(106, 50, 0);
    upd(1, 100, 50, 0);
    fs();
    idle(2);
    px(106, 50, 1);
    idle(2);
`endif

    idle(4);
    chk("sb_drained", exp_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
